// File: rtl/one_hot_to_bcd_enc.sv
// Registered one-hot to binary encoder with a valid/ready handshake and a two-entry skid buffer.
// Define ONE_HOT_CHECK_EN to compile in the malformed-word flag (out_err) and the saturating err_cnt.
module one_hot_to_bcd_enc #(
  parameter int ONE_HOT_WIDTH = 4,
  parameter int BCD_WIDTH     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ONE_HOT_WIDTH-1:0] one_hot_code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BCD_WIDTH-1:0]     bcd_code,
  output logic                     out_err,
  input  logic                     err_clr,
  output logic [7:0]               err_cnt
);

  // Index of the lowest set bit; an all-zero word maps to 0.
  function automatic logic [BCD_WIDTH-1:0] enc_lowest(input logic [ONE_HOT_WIDTH-1:0] v);
    logic [BCD_WIDTH-1:0] idx;
    idx = '0;
    for (int i = ONE_HOT_WIDTH - 1; i >= 0; i--) begin
      if (v[i]) idx = BCD_WIDTH'(i);
    end
    return idx;
  endfunction

  function automatic logic is_malformed(input logic [ONE_HOT_WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < ONE_HOT_WIDTH; i++) begin
      n = n + int'(v[i]);
    end
    return (n != 1);
  endfunction

  logic                 out_vld_q, out_vld_d;
  logic [BCD_WIDTH-1:0] out_code_q, out_code_d;
  logic                 out_err_q, out_err_d;
  logic                 skid_vld_q, skid_vld_d;
  logic [BCD_WIDTH-1:0] skid_code_q, skid_code_d;
  logic                 skid_err_q, skid_err_d;

  logic                 accept;
  logic                 out_free;
  logic [BCD_WIDTH-1:0] in_code;
  logic                 in_err;

  // Ready depends only on the registered SKID state, never on out_ready.
  assign in_ready = !skid_vld_q;
  assign accept   = in_valid && in_ready;
  assign out_free = out_ready || !out_vld_q;
  assign in_code  = enc_lowest(one_hot_code);

  always_comb begin
    out_vld_d   = out_vld_q;
    out_code_d  = out_code_q;
    out_err_d   = out_err_q;
    skid_vld_d  = skid_vld_q;
    skid_code_d = skid_code_q;
    skid_err_d  = skid_err_q;
    if (out_free) begin
      if (skid_vld_q) begin
        // FULL draining: SKID moves up; no accept is possible in this state.
        out_vld_d  = 1'b1;
        out_code_d = skid_code_q;
        out_err_d  = skid_err_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        out_vld_d  = 1'b1;
        out_code_d = in_code;
        out_err_d  = in_err;
      end else begin
        out_vld_d  = 1'b0;
      end
    end else if (accept) begin
      skid_vld_d  = 1'b1;
      skid_code_d = in_code;
      skid_err_d  = in_err;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vld_q   <= 1'b0;
      out_code_q  <= '0;
      out_err_q   <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_code_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      out_vld_q   <= out_vld_d;
      out_code_q  <= out_code_d;
      out_err_q   <= out_err_d;
      skid_vld_q  <= skid_vld_d;
      skid_code_q <= skid_code_d;
      skid_err_q  <= skid_err_d;
    end
  end

  assign out_valid = out_vld_q;
  assign bcd_code  = out_code_q;

`ifdef ONE_HOT_CHECK_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  assign in_err = is_malformed(one_hot_code);

  // Clear has priority over a simultaneous increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (accept && in_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign out_err = out_err_q;
`else
  logic unused_chk;

  assign in_err     = 1'b0;
  assign err_cnt    = '0;
  assign out_err    = 1'b0;
  assign unused_chk = ^{err_clr, out_err_q, is_malformed(one_hot_code)};
`endif

endmodule

// File: tb/tb_one_hot_to_bcd_enc.sv
// Directed bench for one_hot_to_bcd_enc: vector table plus handshake, counter and reset sequences.
module tb_one_hot_to_bcd_enc;

`ifdef ONE_HOT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] one_hot_code;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] bcd_code;
  logic       out_err;
  logic       err_clr;
  logic [7:0] err_cnt;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [3:0] code;
    logic [1:0] bcd;
    logic       bad;
  } vec_t;

  vec_t tbl[8];

  one_hot_to_bcd_enc #(.ONE_HOT_WIDTH(4), .BCD_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .one_hot_code(one_hot_code), .out_valid(out_valid), .out_ready(out_ready),
    .bcd_code(bcd_code), .out_err(out_err), .err_clr(err_clr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_inc(input int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  initial begin
    tbl[0] = '{4'b0001, 2'd0, 1'b0};
    tbl[1] = '{4'b0010, 2'd1, 1'b0};
    tbl[2] = '{4'b0100, 2'd2, 1'b0};
    tbl[3] = '{4'b1000, 2'd3, 1'b0};
    tbl[4] = '{4'b0000, 2'd0, 1'b1};
    tbl[5] = '{4'b0110, 2'd1, 1'b1};
    tbl[6] = '{4'b1111, 2'd0, 1'b1};
    tbl[7] = '{4'b1100, 2'd2, 1'b1};

    reset = 1'b0; in_valid = 1'b0; one_hot_code = 4'b0; out_ready = 1'b0; err_clr = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bcd", 32'(bcd_code), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Streaming at full rate: each word visible right after its accept edge.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      one_hot_code = tbl[i].code;
      step();
      if (tbl[i].bad && CHK) exp_cnt = sat_inc(exp_cnt);
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_bcd", i), 32'(bcd_code), 32'(tbl[i].bcd));
      check($sformatf("vec%0d_err", i), 32'(out_err), 32'(tbl[i].bad & CHK));
      check($sformatf("vec%0d_cnt", i), 32'(err_cnt), 32'(exp_cnt));
      check($sformatf("vec%0d_rdy", i), 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Backpressure: A to OUT, B to SKID, C held off until SKID drains.
    out_ready = 1'b0;
    in_valid = 1'b1; one_hot_code = 4'b0001;
    step();
    check("bp_a_rdy", 32'(in_ready), 32'd1);
    check("bp_a_bcd", 32'(bcd_code), 32'd0);
    one_hot_code = 4'b0010;
    step();
    check("bp_full_rdy", 32'(in_ready), 32'd0);
    check("bp_full_bcd", 32'(bcd_code), 32'd0);
    one_hot_code = 4'b0100;
    step();
    check("bp_hold_rdy", 32'(in_ready), 32'd0);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_bcd", 32'(bcd_code), 32'd0);
    out_ready = 1'b1;
    step();
    check("bp_b_bcd", 32'(bcd_code), 32'd1);
    check("bp_b_valid", 32'(out_valid), 32'd1);
    check("bp_b_rdy", 32'(in_ready), 32'd1);
    step();
    check("bp_c_bcd", 32'(bcd_code), 32'd2);
    check("bp_c_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Counter saturation, then clear racing a malformed accept.
    in_valid = 1'b1; one_hot_code = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      step();
      if (CHK) exp_cnt = sat_inc(exp_cnt);
    end
    check("cnt_sat", 32'(err_cnt), 32'(exp_cnt));
    check("cnt_sat_abs", 32'(err_cnt), CHK ? 32'd255 : 32'd0);
    one_hot_code = 4'b0110; err_clr = 1'b1;
    step();
    exp_cnt = 0;
    check("cnt_clr_wins", 32'(err_cnt), 32'(exp_cnt));
    check("cnt_clr_bcd", 32'(bcd_code), 32'd1);
    check("cnt_clr_err", 32'(out_err), 32'(CHK));
    err_clr = 1'b0;
    step();
    if (CHK) exp_cnt = sat_inc(exp_cnt);
    check("cnt_after_clr", 32'(err_cnt), 32'(exp_cnt));
    in_valid = 1'b0;
    step();

    // Reset while FULL discards both entries at once.
    out_ready = 1'b0; in_valid = 1'b1; one_hot_code = 4'b0100;
    step();
    one_hot_code = 4'b1000;
    step();
    check("full_rdy", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("rstfull_valid", 32'(out_valid), 32'd0);
    check("rstfull_rdy", 32'(in_ready), 32'd1);
    check("rstfull_cnt", 32'(err_cnt), 32'd0);
    check("rstfull_bcd", 32'(bcd_code), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("post_rst_idle%0d", i), 32'(out_valid), 32'd0);
    end
    in_valid = 1'b1; one_hot_code = 4'b1000;
    step();
    check("post_rst_word_valid", 32'(out_valid), 32'd1);
    check("post_rst_word_bcd", 32'(bcd_code), 32'd3);
    in_valid = 1'b0;
    step();
    check("post_rst_end", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/one_hot_to_bcd_enc.md
# one_hot_to_bcd_enc

Registered one-hot-to-binary encoder with a valid/ready handshake and a two-entry skid buffer. It is the inverse of the binary-to-one-hot decoder used in the VC-based router. It converts one-hot grant/VC-select vectors from arbiters back into binary VC/port indices for header fields and credit bookkeeping. It optionally flags and counts malformed (zero or multi-hot) input words.

## Interface
Parameters:
- `ONE_HOT_WIDTH`, 4: width of the one-hot input vector; must be ≥ 2.
- `BCD_WIDTH`, 2: width of the binary output; must equal ceil(log2(`ONE_HOT_WIDTH`)).

Ports:
- `clk`  input  1  the single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  `one_hot_code` holds a word to encode.
- `in_ready`  output  1  the block can accept a word this cycle.
- `one_hot_code`  input  `ONE_HOT_WIDTH`  one-hot input vector.
- `out_valid`  output  1  `bcd_code` and `out_err` are valid.
- `out_ready`  input  1  the downstream block consumes the output this cycle.
- `bcd_code`  output  `BCD_WIDTH`  binary index of the input word.
- `out_err`  output  1  the encoded word was not one-hot.
- `err_clr`  input  1  synchronous clear of `err_cnt`.
- `err_cnt`  output  8  saturating count of malformed words accepted.

## Operation
- Accept event: `in_valid && in_ready` at a rising edge.
- Encoding: `bcd_code` is the index of the lowest set bit of `one_hot_code`.
  - An all-zero input encodes to 0.
  - A multi-hot input encodes to its lowest set index, e.g. 4'b0110 → 1.
- Malformed word: the number of set bits is ≠ 1. Such a word is still forwarded, with `out_err` = 1.
- Storage has two entries: an output register (OUT) and a skid register (SKID). Each entry holds {code, err} plus a valid bit.
- Buffer states and transitions:
  - EMPTY: OUT and SKID both invalid.
  - ONE: only OUT valid.
  - FULL: OUT and SKID both valid.
  - EMPTY + accept → ONE.
  - ONE + accept + `out_ready` → ONE; OUT reloads with the new word.
  - ONE + accept + !`out_ready` → FULL; the new word goes to SKID.
  - ONE + no accept + `out_ready` → EMPTY.
  - FULL + `out_ready` → ONE; SKID moves to OUT.
  - In FULL, no accept is possible.
- `in_ready` = !SKID.valid, driven from a register, not from `out_ready`, so there is no combinational ready path.
- `out_valid` = OUT.valid. `bcd_code` and `out_err` come directly from the OUT register.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- Error counter:
  - Increments by 1 on each accept of a malformed word.
  - Saturates at 255.
  - `err_clr` sets it to 0. If `err_clr` and an increment occur in the same cycle, the clear wins and the result is 0.

## Timing
- Latency: a word accepted at edge N appears on the outputs after edge N (`out_valid` = 1 in cycle N+1), provided OUT is free or drains at edge N.
- Throughput is 1 word/cycle while `out_ready` is held at 1.
- `in_ready` falls in the cycle after SKID fills. It rises in the cycle after SKID drains.
- Reset values, asynchronous on `reset` = 0:
  - `out_valid` = 0, `bcd_code` = 0, `out_err` = 0, `err_cnt` = 0.
  - SKID invalid, so `in_ready` = 1.
- Reset asserted mid-operation: both entries are discarded immediately. No partial word is emitted after release.
- Inputs are sampled only at an accept event. `one_hot_code` may change freely while `in_ready` = 0.
- `err_cnt` updates at the same edge as the accept of the offending word.

## Configuration
- Macro: `ONE_HOT_CHECK_EN`.
- Defined:
  - Population-count check is compiled in.
  - `out_err` and `err_cnt` behave as described above.
  - `err_clr` is active.
- Undefined:
  - Checker and counter logic are removed.
  - `out_err` is tied to 0, `err_cnt` is tied to 0, and `err_clr` is ignored.
  - Encoding, handshake and latency are unchanged.

## Test plan
- Reset, then stream 4'b0001, 4'b0010, 4'b0100, 4'b1000 with `out_ready` = 1 → `bcd_code` 0, 1, 2, 3 on consecutive cycles, each one cycle after accept; `out_err` = 0; `err_cnt` = 0.
- Backpressure: send 3 words with `out_ready` = 0 → first two accepted, `in_ready` = 0 after the second; then raise `out_ready` → all 3 words emerge in order with no loss and no duplicates.
- Malformed inputs with `ONE_HOT_CHECK_EN` defined: 4'b0000 then 4'b0110 → (`bcd_code` 0, `out_err` 1) then (`bcd_code` 1, `out_err` 1); `err_cnt` = 2.
- Counter limits: 300 malformed words → `err_cnt` holds at 255; `err_clr` asserted in the same cycle as a malformed accept → `err_cnt` = 0.
- Reset pulse while in FULL → `out_valid` = 0, `in_ready` = 1 immediately; nothing is emitted after release until a new accept.
- `ONE_HOT_CHECK_EN` undefined, same stimulus as the malformed-input case → same `bcd_code` values; `out_err` = 0; `err_cnt` = 0.
